// File: rtl/nzcv_flag_unit.sv
// NZCV flag unit: single-entry pipeline register that evaluates ARM condition
// codes against the architectural flags and applies S-suffix flag updates.
module nzcv_flag_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_result,
  input  logic        in_n,
  input  logic        in_z,
  input  logic        in_c,
  input  logic        in_v,
  input  logic        in_set_flags,
  input  logic        in_logic,
  input  logic [3:0]  in_cond,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_cond_pass,
  output logic [3:0]  out_flags,
  output logic [3:0]  flags,
  input  logic        wr_flags_en,
  input  logic [3:0]  wr_flags
);

  typedef enum logic {EMPTY, FULL} state_t;

  typedef struct packed {
    logic [31:0] result;
    logic        cond_pass;
    logic [3:0]  flags;
  } entry_t;

  state_t     state;
  entry_t     entry_q;
  entry_t     entry_d;
  logic [3:0] flags_d;
  logic       cond_pass;
  logic       xfer;
  logic       upd;
  logic       f_n, f_z, f_c, f_v;

  assign {f_n, f_z, f_c, f_v} = flags;

  // Condition always sees the registered flags, which already include the
  // previous transfer's update, so back-to-back dependents need no bubble.
  always_comb begin
    cond_pass = 1'b1;
    case (in_cond)
      4'h0: cond_pass = f_z;
      4'h1: cond_pass = !f_z;
      4'h2: cond_pass = f_c;
      4'h3: cond_pass = !f_c;
      4'h4: cond_pass = f_n;
      4'h5: cond_pass = !f_n;
      4'h6: cond_pass = f_v;
      4'h7: cond_pass = !f_v;
      4'h8: cond_pass = f_c && !f_z;
      4'h9: cond_pass = !f_c || f_z;
      4'hA: cond_pass = (f_n == f_v);
      4'hB: cond_pass = (f_n != f_v);
      4'hC: cond_pass = !f_z && (f_n == f_v);
      4'hD: cond_pass = f_z || (f_n != f_v);
      default: cond_pass = 1'b1;
    endcase
  end

  assign in_ready = (state == EMPTY) || out_ready;
  assign xfer     = in_valid && in_ready;
  assign upd      = xfer && cond_pass && in_set_flags;

  // An instruction update beats a same-cycle direct write.
  always_comb begin
    flags_d = flags;
    if (upd)
      flags_d = {in_n, in_z, in_logic ? f_c : in_c, in_logic ? f_v : in_v};
    else if (wr_flags_en)
      flags_d = wr_flags;
  end

  always_comb begin
    entry_d           = '0;
    entry_d.result    = in_result;
    entry_d.cond_pass = cond_pass;
    entry_d.flags     = flags_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      flags   <= 4'b0000;
      entry_q <= '0;
    end else begin
      flags <= flags_d;
      case (state)
        EMPTY: begin
          if (xfer) begin
            state   <= FULL;
            entry_q <= entry_d;
          end
        end
        FULL: begin
          if (xfer)
            entry_q <= entry_d;
          else if (out_ready)
            state <= EMPTY;
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign out_valid     = (state == FULL);
  assign out_result    = entry_q.result;
  assign out_cond_pass = entry_q.cond_pass;
  assign out_flags     = entry_q.flags;

endmodule

// File: tb/tb_nzcv_flag_unit.sv
// Bench for nzcv_flag_unit: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_nzcv_flag_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_result;
  logic        in_n, in_z, in_c, in_v, in_set_flags, in_logic;
  logic [3:0]  in_cond;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_cond_pass;
  logic [3:0]  out_flags;
  logic [3:0]  flags;
  logic        wr_flags_en;
  logic [3:0]  wr_flags;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  nzcv_flag_unit dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_n(in_n), .in_z(in_z), .in_c(in_c), .in_v(in_v),
    .in_set_flags(in_set_flags), .in_logic(in_logic), .in_cond(in_cond),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_cond_pass(out_cond_pass), .out_flags(out_flags),
    .flags(flags), .wr_flags_en(wr_flags_en), .wr_flags(wr_flags)
  );

  always #5 clk = ~clk;

  // ARM-style evaluation: even codes test a base predicate, odd codes invert it.
  function automatic bit model_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = (n == v) && !z;
      default: base = 1'b1;
    endcase
    return (c[0] && c != 4'hF) ? !base : base;
  endfunction

  // Transaction model: one queue slot of depth 1 plus the flag register.
  logic [31:0] m_result;
  logic [3:0]  m_flags, m_oflags;
  bit          m_valid, m_pass;

  always @(posedge clk) begin
    bit rdy, x, p;
    logic [3:0] nf;
    if (rst) begin
      m_valid = 0; m_result = '0; m_pass = 0; m_oflags = '0; m_flags = '0;
    end else begin
      rdy = !m_valid || out_ready;
      x   = in_valid && rdy;
      p   = model_cond(in_cond, m_flags);
      nf  = m_flags;
      if (x && p && in_set_flags)
        nf = {in_n, in_z, in_logic ? m_flags[1] : in_c, in_logic ? m_flags[0] : in_v};
      else if (wr_flags_en)
        nf = wr_flags;
      if (x) begin
        m_valid = 1; m_result = in_result; m_pass = p; m_oflags = nf;
      end else if (out_ready) begin
        m_valid = 0;
      end
      m_flags = nf;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (in_ready !== (!m_valid || out_ready)) begin
        errors++; $display("FAIL cmp_in_ready got=%0b exp=%0b", in_ready, !m_valid || out_ready);
      end
      checks++;
      if (out_valid !== m_valid) begin
        errors++; $display("FAIL cmp_out_valid got=%0b exp=%0b", out_valid, m_valid);
      end
      checks++;
      if (flags !== m_flags) begin
        errors++; $display("FAIL cmp_flags got=%b exp=%b", flags, m_flags);
      end
      if (m_valid) begin
        checks++;
        if (out_result !== m_result || out_cond_pass !== m_pass || out_flags !== m_oflags) begin
          errors++;
          $display("FAIL cmp_entry got=%h/%0b/%b exp=%h/%0b/%b", out_result, out_cond_pass,
                   out_flags, m_result, m_pass, m_oflags);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 0; in_result = '0; {in_n, in_z, in_c, in_v} = 4'b0;
    in_set_flags = 0; in_logic = 0; in_cond = 4'hE;
    wr_flags_en = 0; wr_flags = '0; out_ready = 1;
  endtask

  task automatic drive(input logic [31:0] r, input logic [3:0] nzcv, input bit s,
                       input bit l, input logic [3:0] c);
    in_valid = 1; in_result = r; {in_n, in_z, in_c, in_v} = nzcv;
    in_set_flags = s; in_logic = l; in_cond = c;
  endtask

  task automatic set_flags_to(input logic [3:0] f);
    idle(); wr_flags_en = 1; wr_flags = f; step(); idle();
  endtask

  initial begin
    rst = 1; idle();
    step(); step();
    chk_en = 1;
    chk("reset_flags", {28'd0, flags}, 32'h0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'h0);
    chk("reset_out_result", out_result, 32'h0);
    rst = 0;

    // Logic op keeps C,V from the register.
    set_flags_to(4'b0011);
    drive(32'h0, 4'b0100, 1, 1, 4'hE); step(); idle();
    chk("logic_out_flags", {28'd0, out_flags}, 32'h7);
    chk("logic_flags", {28'd0, flags}, 32'h7);
    chk("logic_pass", {31'd0, out_cond_pass}, 32'h1);
    step();

    // Failed condition: entry still shows up, flags hold.
    set_flags_to(4'b0000);
    drive(32'h1234_5678, 4'b1000, 1, 0, 4'h0); step(); idle();
    chk("fail_pass", {31'd0, out_cond_pass}, 32'h0);
    chk("fail_flags", {28'd0, flags}, 32'h0);
    chk("fail_result", out_result, 32'h1234_5678);
    chk("fail_valid", {31'd0, out_valid}, 32'h1);
    step();

    // Zero-bubble forwarding: EQ sees Z from the previous transfer, HI fails.
    set_flags_to(4'b0000);
    drive(32'h1, 4'b0110, 1, 0, 4'hE); step();
    drive(32'h2, 4'b0000, 0, 0, 4'h0); step(); idle();
    chk("fwd_eq_pass", {31'd0, out_cond_pass}, 32'h1);
    step();
    set_flags_to(4'b0000);
    drive(32'h1, 4'b0110, 1, 0, 4'hE); step();
    drive(32'h3, 4'b0000, 0, 0, 4'h8); step(); idle();
    chk("fwd_hi_pass", {31'd0, out_cond_pass}, 32'h0);
    chk("fwd_flags", {28'd0, flags}, 32'h6);
    step();

    // Backpressure holds the entry; pending transfer goes when out_ready rises.
    out_ready = 0;
    drive(32'h1111_2222, 4'b0000, 0, 0, 4'hE); step();
    drive(32'hDEAD_BEEF, 4'b0000, 0, 0, 4'hE);
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", {31'd0, in_ready}, 32'h0);
      chk("bp_out_result", out_result, 32'h1111_2222);
      step();
    end
    out_ready = 1; #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'h1);
    step(); idle();
    chk("bp_new_result", out_result, 32'hDEAD_BEEF);
    step();

    // Write collision: instruction update wins; alone, the write lands.
    set_flags_to(4'b0000);
    drive(32'h5, 4'b0001, 1, 0, 4'hE); wr_flags_en = 1; wr_flags = 4'b1111; step(); idle();
    chk("coll_flags", {28'd0, flags}, 32'h1);
    chk("coll_out_flags", {28'd0, out_flags}, 32'h1);
    wr_flags_en = 1; wr_flags = 4'b1111; step(); idle();
    chk("wr_only_flags", {28'd0, flags}, 32'hF);

    // Reset while FULL and stalled.
    set_flags_to(4'b1010);
    out_ready = 0;
    drive(32'h77, 4'b0000, 0, 0, 4'hE); step();
    in_valid = 0;
    chk("pre_rst_valid", {31'd0, out_valid}, 32'h1);
    chk("pre_rst_flags", {28'd0, flags}, 32'hA);
    rst = 1; wr_flags_en = 1; wr_flags = 4'b1111; in_valid = 1;
    step();
    rst = 0; idle(); out_ready = 0;
    chk("rst_valid", {31'd0, out_valid}, 32'h0);
    chk("rst_flags", {28'd0, flags}, 32'h0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'h1);
    chk("rst_out_result", out_result, 32'h0);
    step(); idle();

    // Mixed traffic: all condition codes, random stalls, writes and resets.
    for (int i = 0; i < 600; i++) begin
      in_valid     = ($urandom_range(3) != 0);
      in_result    = $urandom;
      {in_n, in_z, in_c, in_v} = 4'($urandom);
      in_set_flags = ($urandom_range(3) != 0);
      in_logic     = ($urandom_range(3) == 0);
      in_cond      = 4'($urandom);
      wr_flags_en  = ($urandom_range(7) == 0);
      wr_flags     = 4'($urandom);
      out_ready    = ($urandom_range(3) != 0);
      rst          = ($urandom_range(63) == 0);
      step();
    end
    rst = 0; idle(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nzcv_flag_unit.md
NZCV_FLAG_UNIT -- requirements
Module: nzcv_flag_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
REQ-002 The ALU-side (upstream) ports SHALL be:
- in_valid  input  1  ALU result/flags valid
- in_ready  output  1  unit can accept this cycle
- in_result  input  32  ALU result
- in_n, in_z, in_c, in_v  input  1 each  ALU flags
- in_set_flags  input  1  instruction updates NZCV (S suffix)
- in_logic  input  1  logic op (AND/ORR/EOR/MOV...): keep C,V
- in_cond  input  4  ARM condition code
REQ-003 The downstream ports SHALL be:
- out_valid  output  1  output register holds an entry
- out_ready  input  1  consumer accepts this cycle
- out_result  output  32  registered result
- out_cond_pass  output  1  condition held for this entry
- out_flags  output  4  {N,Z,C,V} after this entry's update
REQ-004 The architectural flag ports SHALL be:
- flags  output  4  architectural {N,Z,C,V}, bit3=N, bit0=V
- wr_flags_en  input  1  direct flag write (MSR-style)
- wr_flags  input  4  value for direct write

Function
REQ-005 A transfer SHALL occur on a cycle where in_valid && in_ready.
REQ-006 in_ready SHALL equal (!out_valid || out_ready), combinationally; the unit is a single-entry pipeline register with full throughput.
REQ-007 States SHALL be EMPTY (out_valid=0) and FULL (out_valid=1). Transitions:
- EMPTY→FULL on a transfer.
- FULL→EMPTY on out_ready with no transfer.
- FULL→FULL on out_ready with a transfer.
- FULL stays FULL when out_ready=0.
REQ-008 The condition SHALL be evaluated combinationally against the current flags register, never the incoming in_n..in_v:
- 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
- 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V)
- E AL 1; F 1
REQ-009 On a transfer with condition pass and in_set_flags=1, flags SHALL update on the next edge:
- N←in_n, Z←in_z
- C←(in_logic ? flags.C : in_c)
- V←(in_logic ? flags.V : in_v)
REQ-010 On a transfer with condition fail, or with in_set_flags=0, flags SHALL hold.
REQ-011 On a transfer, out_result←in_result, out_cond_pass←the evaluated condition, and out_flags←the flag value flags will hold after this edge.
REQ-012 A failed-condition entry SHALL still be presented downstream with out_cond_pass=0, so the consumer can discard it.
REQ-013 With wr_flags_en=1, flags←wr_flags on the next edge, unless the same cycle contains a transfer that updates flags per REQ-009; in that case the instruction update wins and wr_flags is dropped.
REQ-014 Back-to-back transfers SHALL see the flags produced by the previous transfer, with zero bubble: the cycle-n+1 condition uses flags written at the end of cycle n.
REQ-015 While FULL and out_ready=0:
- out_result, out_cond_pass and out_flags SHALL be stable.
- flags SHALL change only via wr_flags_en.

Reset
REQ-016 When rst=1 at an edge, the unit SHALL set flags=4'b0000, out_valid=0, out_result=0, out_cond_pass=0 and out_flags=0, regardless of any in-flight transfer or wr_flags_en.
REQ-017 During reset, in_ready SHALL follow REQ-006; any transfer in that cycle is discarded, and flags stay 0.
REQ-018 The first edge after rst deasserts SHALL behave as normal operation from the EMPTY state.

Verification
REQ-019 Logic-op flag rule: flags=4'b0011, transfer in_result=0, n=0 z=1 c=0 v=0, set_flags=1, logic=1, cond=E. Required: out_flags=4'b0111, flags=4'b0111, out_cond_pass=1.
REQ-020 Failed condition: flags=4'b0000, transfer cond=0 (EQ), set_flags=1, n=1. Required: out_cond_pass=0, flags remain 4'b0000, out_result still = in_result.
REQ-021 Zero-bubble flag forwarding: flags=0. Cycle n: arith transfer set_flags=1, z=1, c=1. Cycle n+1: transfer cond=0 (EQ). Required: second entry out_cond_pass=1. Repeat with cond=8 (HI); required out_cond_pass=0.
REQ-022 Backpressure: hold out_ready=0 for 3 cycles after a transfer, with in_valid=1 and in_result=32'hDEADBEEF pending. Required:
- in_ready=0 for those cycles.
- out_result stable.
- The pending entry transfers on the cycle out_ready rises.
REQ-023 Write collision: same cycle, wr_flags_en=1 with wr_flags=4'b1111, and a passing set_flags arith transfer with n=0 z=0 c=0 v=1. Required: flags=4'b0001. Repeat with no transfer; required flags=4'b1111.
REQ-024 Reset mid-operation: FULL with out_ready=0 and flags=4'b1010; assert rst for one cycle. Required: out_valid=0, flags=0, in_ready=1 on the following cycle.
